demux1pn_buf: RTL
=================

Name: demux1pn_buf

Overview:
- Parametrised successor to the 1:4 demux: routes one input stream to one of N_OUT output channels, each WIDTH bits wide.
- Uses valid/ready handshakes on input and on every output.
- Each output channel has a one-entry registered buffer, so a stalled channel does not lose data and idle channels still accept traffic.
- Sits between a single producer and N_OUT independent consumers.

Parameters:
- WIDTH, 8, data bits per transfer
- N_OUT, 4, number of output channels; legal range 2..16
- SEL_W, derived ceil(log2(N_OUT)), select width; not user-overridable

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous reset, active-high
- data_in  input  WIDTH  input payload
- sel  input  SEL_W  destination channel index, sampled with data_in
- in_valid  input  1  producer offers data_in/sel
- in_ready  output  1  block accepts this cycle
- out_data  output  N_OUT*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH]
- out_valid  output  N_OUT  channel k buffer holds data
- out_ready  input  N_OUT  consumer k takes data
- drop  output  1  one-cycle pulse: an accepted beat was discarded because sel >= N_OUT

Behaviour:
- Reset (async assert, sync release):
  - out_valid = 0, out_data = 0, drop = 0.
  - in_ready reflects the empty buffers combinationally, so it is 1 whenever sel is valid.
- Per-channel slot FSM, two states:
  - EMPTY -> FULL on an input transfer to k.
  - FULL -> EMPTY on out_ready[k] with no new write.
  - FULL -> FULL on a simultaneous pop and write to k (pass-through refill).
- in_ready:
  - If sel < N_OUT: in_ready = !out_valid[sel] | out_ready[sel].
  - If sel >= N_OUT: in_ready = 1.
  - Combinational path from out_ready to in_ready is intended; no skid buffer.
- Input transfer happens when in_valid & in_ready.
  - The beat is registered into slot sel.
  - out_valid[sel] = 1 and out_data slice = data_in on the next cycle. Latency is exactly 1 cycle.
- Output transfer happens when out_valid[k] & out_ready[k]. With no refill, out_valid[k] clears next cycle.
- out_data slice holds its last value after the slot empties; it is never zeroed except by reset.
- Channels are independent:
  - A stalled channel never blocks transfers to other channels.
  - Order within a channel is preserved trivially (depth 1).
- Invalid sel (only possible when N_OUT is not a power of two):
  - The beat is accepted and discarded.
  - drop pulses high for exactly one cycle, registered.
  - No slot changes.
- in_valid low: no state change; sel and data_in are don't-care.
- Reset mid-operation: all buffered beats are lost; out_valid clears immediately (async).

Optional Feature:
- Macro: DEMUX_STATS_EN.
- Defined:
  - Adds output port stat_cnt (N_OUT*16 bits). Slice k is a 16-bit saturating count of completed output transfers on channel k.
  - Counters reset to 0 and hold at 16'hFFFF.
  - Adds input port stat_clr (1 bit), which synchronously zeroes all counters.
  - stat_clr has priority over an increment in the same cycle.
- Undefined: neither port exists and no counter logic is generated. Handshake behaviour is identical either way.

Decomposition:
- Shared package demux_pkg holds:
  - a sel_width(n) constant function;
  - localparam STAT_W = 16;
  - localparam STAT_MAX = 16'hFFFF.
- Sub-module demux_slot: one-entry valid/data register with push/pop, parametrised on WIDTH. Instantiated N_OUT times via generate.

Test Plan:
- Reset release, WIDTH=8, N_OUT=4; sel=2, data_in=8'hA5, in_valid one cycle, out_ready=4'b1111 -> out_valid=4'b0100 and out_data[23:16]=8'hA5 exactly one cycle later, cleared the following cycle.
- out_ready[1]=0; write 8'h11 to sel=1, then a second beat to sel=1 -> in_ready=0 on the second beat. Meanwhile a beat 8'h33 to sel=3 is accepted and appears on channel 3. Raising out_ready[1] -> in_ready=1 the same cycle, and the channel 1 refill completes (FULL->FULL).
- Back-to-back beats sel=0,1,2,3 with data 1,2,3,4, all out_ready=1 -> each appears on its channel one cycle after acceptance, one transfer per cycle, no bubbles.
- N_OUT=3, sel=3, in_valid=1 -> in_ready=1, drop pulses one cycle, out_valid stays 3'b000.
- Assert rst while channels 0 and 2 are FULL -> out_valid=0 and out_data=0 immediately. After release, a new beat to sel=0 behaves as in the first scenario.
- DEMUX_STATS_EN defined: 3 pops on channel 0 -> stat_cnt[15:0]=3; pulse stat_clr together with a pop -> count becomes 0. Force a counter to 16'hFFFF, then pop -> it stays at 16'hFFFF.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared constants, types and helpers for the demux1pn_buf channel router.
package demux_pkg;

    localparam int          STAT_W   = 16;
    localparam logic [15:0] STAT_MAX = 16'hFFFF;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

    // A select port must be at least one bit wide even for degenerate counts.
    function automatic int sel_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/demux_slot.sv
// One-entry output buffer: holds a single beat until its consumer pops it.
module demux_slot
    import demux_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
);

    slot_state_e      state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;

    // A push while full is a pass-through refill; data is never cleared on pop.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        case (state_q)
            SLOT_EMPTY: begin
                if (push_i) begin
                    state_d = SLOT_FULL;
                    data_d  = data_i;
                end
            end
            SLOT_FULL: begin
                if (push_i) begin
                    state_d = SLOT_FULL;
                    data_d  = data_i;
                end else if (pop_i) begin
                    state_d = SLOT_EMPTY;
                end
            end
            default: state_d = SLOT_EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= SLOT_EMPTY;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = (state_q == SLOT_FULL);
    assign data_o  = data_q;

endmodule

// File: rtl/demux1pn_buf.sv
// 1:N_OUT valid/ready demux with a one-entry buffer per channel.
// Optional DEMUX_STATS_EN adds per-channel saturating pop counters (stat_cnt/stat_clr).
module demux1pn_buf
    import demux_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int N_OUT = 4,
    localparam int SEL_W = sel_width(N_OUT)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [WIDTH-1:0]       data_in,
    input  logic [SEL_W-1:0]       sel,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [N_OUT*WIDTH-1:0] out_data,
    output logic [N_OUT-1:0]       out_valid,
    input  logic [N_OUT-1:0]       out_ready,
    output logic                   drop
`ifdef DEMUX_STATS_EN
    ,
    input  logic                   stat_clr,
    output logic [N_OUT*STAT_W-1:0] stat_cnt
`endif
);

    logic [N_OUT-1:0] selHit;
    logic             selInRange;
    logic [N_OUT-1:0] push;
    logic [N_OUT-1:0] pop;
    logic             drop_q, drop_d;

    // Decode by comparison rather than indexing so out-of-range selects stay safe.
    always_comb begin
        selHit = '0;
        for (int k = 0; k < N_OUT; k++) begin
            selHit[k] = (sel == SEL_W'(k));
        end
        selInRange = |selHit;
        in_ready   = !selInRange || (|(selHit & (~out_valid | out_ready)));
    end

    assign push   = (in_valid && in_ready) ? selHit : '0;
    assign pop    = out_valid & out_ready;
    assign drop_d = in_valid && !selInRange;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_q <= 1'b0;
        end else begin
            drop_q <= drop_d;
        end
    end

    assign drop = drop_q;

    for (genvar k = 0; k < N_OUT; k++) begin : g_slot
        demux_slot #(
            .WIDTH (WIDTH)
        ) u_slot (
            .clk     (clk),
            .rst     (rst),
            .push_i  (push[k]),
            .pop_i   (pop[k]),
            .data_i  (data_in),
            .valid_o (out_valid[k]),
            .data_o  (out_data[k*WIDTH +: WIDTH])
        );
    end

`ifdef DEMUX_STATS_EN
    // Clear wins over a same-cycle pop; counters stick at their maximum.
    for (genvar k = 0; k < N_OUT; k++) begin : g_stat
        logic [STAT_W-1:0] cnt_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt_q <= '0;
            end else if (stat_clr) begin
                cnt_q <= '0;
            end else if (pop[k] && (cnt_q != STAT_MAX)) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end

        assign stat_cnt[k*STAT_W +: STAT_W] = cnt_q;
    end
`endif

endmodule
